game_flow_controller: RTL and testbench
=======================================

// Module: game_flow_controller
// PURPOSE
//   Top-level Breakout game sequencer. Tracks lives and score, paces serves, and drives
//   game_over_display: issues the one-cycle trigger_game_over pulse and waits for
//   game_over_complete before returning to idle. Sits between paddle/ball/brick logic and the display layer.
// PARAMETERS
//   START_LIVES      3     lives loaded at game start (1..2**LIVES_W-1)
//   LIVES_W          2     width of lives counter
//   SCORE_W          16    width of score counter
//   BRICK_POINTS     1     points added per brick_hit
//   SERVE_DELAY      50_000_000  cycles held in SERVE before launch (1 s @ 50 MHz)
//   LOST_DELAY       25_000_000  cycles held in LIFE_LOST before next SERVE
// PORTS
//   clk                 in   1        50 MHz system clock
//   reset               in   1        asynchronous, active-high reset
//   start_btn           in   1        debounced start level; rising edge detected internally
//   brick_hit           in   1        1-cycle pulse from brick logic
//   ball_lost           in   1        1-cycle pulse: ball passed paddle
//   all_bricks_cleared  in   1        1-cycle pulse: last brick removed
//   game_over_complete  in   1        from game_over_display: end-of-screen done
//   trigger_game_over   out  1        1-cycle pulse to game_over_display
//   round_reset         out  1        1-cycle pulse: reload brick field / centre paddle
//   ball_launch         out  1        1-cycle pulse: release ball from paddle
//   game_active         out  1        high in SERVE, PLAY, LIFE_LOST
//   lives               out  LIVES_W  remaining lives
//   score               out  SCORE_W  current score
//   state_dbg           out  3        encoded FSM state for debug
// BEHAVIOUR
//   Reset: state=IDLE, lives=START_LIVES, score=0, all pulses 0, game_active=0; async, takes
//     effect immediately, also aborts any count or pending GAME_OVER wait.
//   All outputs registered; every pulse is exactly one clk wide.
//   States: IDLE=0, SERVE=1, PLAY=2, LIFE_LOST=3, GAME_OVER=4.
//   IDLE: start_btn 0->1 edge -> SERVE; same edge: lives<=START_LIVES, score<=0, round_reset=1.
//     Level high start_btn at reset release is not an edge.
//   SERVE: delay counter cleared on entry; after SERVE_DELAY cycles -> PLAY, ball_launch=1
//     on the transition cycle.
//   PLAY: brick_hit -> score+=BRICK_POINTS, saturating at 2**SCORE_W-1 (no wrap).
//     all_bricks_cleared -> SERVE, round_reset=1, lives unchanged.
//     ball_lost with lives>1 -> lives-=1, LIFE_LOST.
//     ball_lost with lives==1 -> lives<=0, GAME_OVER, trigger_game_over=1 next cycle.
//   Simultaneous events in PLAY: brick_hit scoring always applied in the same cycle;
//     all_bricks_cleared has priority over ball_lost (no life lost).
//   LIFE_LOST: counter cleared on entry; after LOST_DELAY cycles -> SERVE (no round_reset).
//   GAME_OVER: trigger_game_over pulsed once on entry only; score and lives held;
//     start_btn ignored; game_over_complete=1 -> IDLE next cycle.
//   brick_hit, ball_lost, all_bricks_cleared ignored outside PLAY; game_over_complete
//     ignored outside GAME_OVER; never re-triggers.
//   Delay counters sized $clog2(max(SERVE_DELAY,LOST_DELAY))+1; delay value N gives exactly N cycles.
// TESTING (20 ns clk; SERVE_DELAY=4, LOST_DELAY=3, START_LIVES=3)
//   Reset held 100 ns then start_btn 0->1 -> round_reset 1 cycle, SERVE, 4 cycles later
//     ball_launch 1 cycle, state_dbg=2, lives=3, score=0.
//   5 brick_hit pulses in PLAY -> score=5; with SCORE_W=4, 20 hits -> score=15 (saturated).
//   ball_lost x3 (re-serving between) -> lives 2,1, then trigger_game_over single pulse,
//     state_dbg=4; extra ball_lost/start_btn in GAME_OVER -> no second pulse, no change.
//   game_over_complete=1 in GAME_OVER -> IDLE next cycle, game_active=0, score held until
//     next start edge clears it.
//   ball_lost and all_bricks_cleared same cycle with lives=1 -> SERVE, round_reset=1, lives=1,
//     no trigger_game_over.
//   reset asserted mid-SERVE and mid-GAME_OVER -> immediately IDLE, all outputs at reset values.

Source files
------------

// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
//
// Top-level Breakout game sequencer. Tracks remaining lives and the score,
// paces the serve and life-lost pauses, and hands off to the game-over display.
// The display gets a one-cycle trigger_game_over pulse. This block then waits
// for game_over_complete before it returns to idle.
//
// Ports
//   clk                 in   1        system clock (50 MHz nominal)
//   reset               in   1        asynchronous, active-high reset
//   start_btn           in   1        debounced start level; rising edge used
//   brick_hit           in   1        1-cycle pulse: a brick was hit
//   ball_lost           in   1        1-cycle pulse: ball passed the paddle
//   all_bricks_cleared  in   1        1-cycle pulse: last brick removed
//   game_over_complete  in   1        game-over screen has finished
//   trigger_game_over   out  1        1-cycle pulse to the game-over display
//   round_reset         out  1        1-cycle pulse: reload bricks, centre paddle
//   ball_launch         out  1        1-cycle pulse: release ball from paddle
//   game_active         out  1        high in SERVE, PLAY and LIFE_LOST
//   lives               out  LIVES_W  remaining lives
//   score               out  SCORE_W  current score (saturating)
//   state_dbg           out  3        encoded FSM state
//                                     (IDLE=0 SERVE=1 PLAY=2 LIFE_LOST=3
//                                      GAME_OVER=4)
//
// Handshake: every event input and every pulse output is a single-cycle
// strobe. There is no valid/ready backpressure. An input strobe counts only in
// the state that consumes it, and is dropped silently in any other state.
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module game_flow_controller #(
    parameter int START_LIVES  = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_W      = 16,
    parameter int BRICK_POINTS = 1,
    parameter int SERVE_DELAY  = 50_000_000,
    parameter int LOST_DELAY   = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               brick_hit,
    input  logic               ball_lost,
    input  logic               all_bricks_cleared,
    input  logic               game_over_complete,
    output logic               trigger_game_over,
    output logic               round_reset,
    output logic               ball_launch,
    output logic               game_active,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_LIFE_LOST = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    // The pause counter is shared by SERVE and LIFE_LOST. It is sized for the
    // longer of the two pauses, with one bit of headroom.
    localparam int MAX_DELAY = (SERVE_DELAY > LOST_DELAY) ? SERVE_DELAY : LOST_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY) + 1;

    // The counter starts at 0 on entry and the exit fires when it reaches
    // DELAY-1. A delay of N therefore holds the state for exactly N cycles.
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0]   LOST_LAST  = CNT_W'(LOST_DELAY - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

    // Score arithmetic is one bit wider so an overflow can be seen and clamped.
    localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0] POINTS    = (SCORE_W + 1)'(BRICK_POINTS);

    state_t             state;
    logic [CNT_W-1:0]   delay_cnt;
    logic               start_prev;

    logic               start_rise;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               last_life;

    // start_prev resets to 1. A button already held when reset is released is
    // therefore not taken as a press; it has to go low and then high again.
    assign start_rise = start_btn & ~start_prev;

    assign score_sum  = {1'b0, score} + POINTS;
    assign score_sat  = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                                : score_sum[SCORE_W-1:0];

    assign last_life  = (lives == LIVES_ONE);

    assign state_dbg  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            delay_cnt         <= '0;
            start_prev        <= 1'b1;
            lives             <= LIVES_INIT;
            score             <= '0;
            trigger_game_over <= 1'b0;
            round_reset       <= 1'b0;
            ball_launch       <= 1'b0;
            game_active       <= 1'b0;
        end else begin
            start_prev        <= start_btn;

            // Pulse outputs fall back to 0 every cycle unless a transition
            // below sets them. This keeps each pulse exactly one cycle wide.
            trigger_game_over <= 1'b0;
            round_reset       <= 1'b0;
            ball_launch       <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The score from the previous game stays visible here
                    // until the next start press clears it.
                    if (start_rise) begin
                        state       <= S_SERVE;
                        delay_cnt   <= '0;
                        lives       <= LIVES_INIT;
                        score       <= '0;
                        round_reset <= 1'b1;
                        game_active <= 1'b1;
                    end
                end

                S_SERVE: begin
                    if (delay_cnt == SERVE_LAST) begin
                        state       <= S_PLAY;
                        delay_cnt   <= '0;
                        ball_launch <= 1'b1;
                    end else begin
                        delay_cnt   <= delay_cnt + CNT_W'(1);
                    end
                end

                S_PLAY: begin
                    // A brick hit scores even when the same cycle also ends
                    // the round or loses the ball.
                    if (brick_hit) begin
                        score <= score_sat;
                    end

                    // A cleared field takes priority over a lost ball. That
                    // cycle always starts a fresh round and costs no life.
                    if (all_bricks_cleared) begin
                        state       <= S_SERVE;
                        delay_cnt   <= '0;
                        round_reset <= 1'b1;
                    end else if (ball_lost) begin
                        if (last_life) begin
                            state             <= S_GAME_OVER;
                            lives             <= '0;
                            trigger_game_over <= 1'b1;
                            game_active       <= 1'b0;
                        end else begin
                            state     <= S_LIFE_LOST;
                            delay_cnt <= '0;
                            lives     <= lives - LIVES_ONE;
                        end
                    end
                end

                S_LIFE_LOST: begin
                    // Re-serving after a lost ball keeps the current brick
                    // field, so no round_reset is issued here.
                    if (delay_cnt == LOST_LAST) begin
                        state     <= S_SERVE;
                        delay_cnt <= '0;
                    end else begin
                        delay_cnt <= delay_cnt + CNT_W'(1);
                    end
                end

                S_GAME_OVER: begin
                    // The trigger pulse is issued only on the transition into
                    // this state. Score, lives and start_btn are all ignored
                    // while waiting for the display to finish.
                    if (game_over_complete) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    delay_cnt   <= '0;
                    game_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_game_flow_controller
//
// Directed bench for game_flow_controller. It uses short delays: SERVE=4
// cycles, LOST=3 cycles, START_LIVES=3.
//
// Two instances share every input. Instance dut uses the default 16-bit score.
// Instance dut_sat uses a 4-bit score to exercise saturation.
//
// Inputs are driven 1 ns after a rising edge. Outputs are sampled at that same
// point, after the edge that registered them.
// -----------------------------------------------------------------------------
module tb_game_flow_controller;

    logic        clk;
    logic        reset;
    logic        start_btn;
    logic        brick_hit;
    logic        ball_lost;
    logic        all_bricks_cleared;
    logic        game_over_complete;

    logic        trigger_game_over;
    logic        round_reset;
    logic        ball_launch;
    logic        game_active;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  state_dbg;

    logic        sat_trigger_game_over;
    logic        sat_round_reset;
    logic        sat_ball_launch;
    logic        sat_game_active;
    logic [1:0]  sat_lives;
    logic [3:0]  sat_score;
    logic [2:0]  sat_state_dbg;

    // Observed control vector:
    //   {state_dbg, lives, game_active, round_reset, ball_launch, trigger_game_over}
    logic [8:0]  obs;
    assign obs = {state_dbg, lives, game_active, round_reset, ball_launch, trigger_game_over};

    int checks = 0;
    int errors = 0;

    game_flow_controller #(
        .START_LIVES(3), .LIVES_W(2), .SCORE_W(16), .BRICK_POINTS(1),
        .SERVE_DELAY(4), .LOST_DELAY(3)
    ) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .brick_hit(brick_hit),
        .ball_lost(ball_lost), .all_bricks_cleared(all_bricks_cleared),
        .game_over_complete(game_over_complete),
        .trigger_game_over(trigger_game_over), .round_reset(round_reset),
        .ball_launch(ball_launch), .game_active(game_active),
        .lives(lives), .score(score), .state_dbg(state_dbg)
    );

    game_flow_controller #(
        .START_LIVES(3), .LIVES_W(2), .SCORE_W(4), .BRICK_POINTS(1),
        .SERVE_DELAY(4), .LOST_DELAY(3)
    ) dut_sat (
        .clk(clk), .reset(reset), .start_btn(start_btn), .brick_hit(brick_hit),
        .ball_lost(ball_lost), .all_bricks_cleared(all_bricks_cleared),
        .game_over_complete(game_over_complete),
        .trigger_game_over(sat_trigger_game_over), .round_reset(sat_round_reset),
        .ball_launch(sat_ball_launch), .game_active(sat_game_active),
        .lives(sat_lives), .score(sat_score), .state_dbg(sat_state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic brick_pulse();
        brick_hit = 1'b1;
        tick();
        brick_hit = 1'b0;
        tick();
    endtask

    task automatic lose_ball();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
    endtask

    // Bounded wait for a given state; a timeout counts as a failed check.
    task automatic wait_state(input logic [2:0] target, input string name);
        int n;
        n = 0;
        while (state_dbg !== target && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (state_dbg !== target) begin
            errors++;
            $display("FAIL %s: timeout, state_dbg=%0d expected %0d", name, state_dbg, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start_btn = 1'b1;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        all_bricks_cleared = 1'b0;
        game_over_complete = 1'b0;
        #100;
        checks++;
        if (obs !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_obs: got %h expected %h", obs, {3'd0, 2'd3, 4'b0});
        end
        checks++;
        if (score !== 16'd0 || sat_score !== 4'd0) begin
            errors++; $display("FAIL reset_score: got %0d/%0d expected 0/0", score, sat_score);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(); tick(); tick();
        // A start level that is already high at release must not start a game.
        checks++;
        if (obs !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL level_not_edge: got %h expected %h", obs, {3'd0, 2'd3, 4'b0});
        end
    endtask

    task automatic test_start_serve();
        press_start();
        checks++;
        if (obs !== {3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL start_edge: got %h expected %h", obs, {3'd1, 2'd3, 4'b1100});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {3'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL serve_hold%0d: got %h expected %h", i, obs, {3'd1, 2'd3, 4'b1000});
            end
        end
        tick();
        checks++;
        if (obs !== {3'd2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0} || score !== 16'd0) begin
            errors++; $display("FAIL launch: got %h score %0d expected %h score 0", obs, score, {3'd2, 2'd3, 4'b1010});
        end
        tick();
        checks++;
        if (obs !== {3'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL launch_width: got %h expected %h", obs, {3'd2, 2'd3, 4'b1000});
        end
    endtask

    task automatic test_scoring();
        for (int i = 0; i < 5; i++) brick_pulse();
        checks++;
        if (score !== 16'd5 || sat_score !== 4'd5) begin
            errors++; $display("FAIL score5: got %0d/%0d expected 5/5", score, sat_score);
        end
        // game_over_complete outside GAME_OVER has no effect.
        game_over_complete = 1'b1;
        tick();
        game_over_complete = 1'b0;
        checks++;
        if (obs !== {3'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL goc_ignored: got %h expected %h", obs, {3'd2, 2'd3, 4'b1000});
        end
        for (int i = 0; i < 10; i++) brick_pulse();
        checks++;
        if (score !== 16'd15 || sat_score !== 4'd15) begin
            errors++; $display("FAIL score15: got %0d/%0d expected 15/15", score, sat_score);
        end
        for (int i = 0; i < 5; i++) brick_pulse();
        checks++;
        if (score !== 16'd20 || sat_score !== 4'd15) begin
            errors++; $display("FAIL score_saturate: got %0d/%0d expected 20/15", score, sat_score);
        end
    endtask

    task automatic test_lives();
        int trig_cnt;
        lose_ball();
        checks++;
        if (obs !== {3'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL life_lost1: got %h expected %h", obs, {3'd3, 2'd2, 4'b1000});
        end
        tick(); tick();
        checks++;
        if (state_dbg !== 3'd3) begin
            errors++; $display("FAIL lost_hold: got %0d expected 3", state_dbg);
        end
        tick();
        checks++;
        if (obs !== {3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reserve_no_round_reset: got %h expected %h", obs, {3'd1, 2'd2, 4'b1000});
        end
        wait_state(3'd2, "wait_play_a");
        checks++;
        if (obs !== {3'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL relaunch: got %h expected %h", obs, {3'd2, 2'd2, 4'b1010});
        end
        lose_ball();
        checks++;
        if (lives !== 2'd1 || state_dbg !== 3'd3) begin
            errors++; $display("FAIL life_lost2: got lives %0d state %0d expected 1/3", lives, state_dbg);
        end
        wait_state(3'd2, "wait_play_b");
        lose_ball();
        checks++;
        if (obs !== {3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1} || score !== 16'd20 || sat_score !== 4'd15) begin
            errors++; $display("FAIL game_over_entry: got %h score %0d expected %h score 20", obs, score, {3'd4, 2'd0, 4'b0001});
        end
        // Stray events and start presses in GAME_OVER change nothing.
        trig_cnt = 0;
        start_btn = 1'b0;
        tick(); trig_cnt += int'(trigger_game_over);
        start_btn = 1'b1;
        tick(); trig_cnt += int'(trigger_game_over);
        ball_lost = 1'b1; brick_hit = 1'b1; all_bricks_cleared = 1'b1;
        tick(); trig_cnt += int'(trigger_game_over);
        ball_lost = 1'b0; brick_hit = 1'b0; all_bricks_cleared = 1'b0;
        tick(); trig_cnt += int'(trigger_game_over);
        checks++;
        if (trig_cnt !== 0) begin
            errors++; $display("FAIL single_trigger: got %0d extra pulses expected 0", trig_cnt);
        end
        checks++;
        if (obs !== {3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0} || score !== 16'd20) begin
            errors++; $display("FAIL game_over_hold: got %h score %0d expected %h score 20", obs, score, {3'd4, 6'd0});
        end
    endtask

    task automatic test_game_over_complete();
        game_over_complete = 1'b1;
        tick();
        game_over_complete = 1'b0;
        checks++;
        if (obs !== {3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0} || score !== 16'd20) begin
            errors++; $display("FAIL to_idle: got %h score %0d expected %h score 20", obs, score, 9'h000);
        end
        game_over_complete = 1'b1;
        tick();
        game_over_complete = 1'b0;
        start_btn = 1'b0;
        tick();
        checks++;
        if (state_dbg !== 3'd0 || score !== 16'd20) begin
            errors++; $display("FAIL idle_hold: got state %0d score %0d expected 0/20", state_dbg, score);
        end
        start_btn = 1'b1;
        tick();
        checks++;
        if (obs !== {3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0} || score !== 16'd0 || sat_score !== 4'd0) begin
            errors++; $display("FAIL restart: got %h score %0d expected %h score 0", obs, score, {3'd1, 2'd3, 4'b1100});
        end
    endtask

    task automatic test_simultaneous();
        wait_state(3'd2, "wait_play_c");
        lose_ball();
        wait_state(3'd2, "wait_play_d");
        lose_ball();
        wait_state(3'd2, "wait_play_e");
        checks++;
        if (lives !== 2'd1) begin
            errors++; $display("FAIL setup_lives1: got %0d expected 1", lives);
        end
        ball_lost = 1'b1; all_bricks_cleared = 1'b1; brick_hit = 1'b1;
        tick();
        ball_lost = 1'b0; all_bricks_cleared = 1'b0; brick_hit = 1'b0;
        checks++;
        if (obs !== {3'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0} || score !== 16'd1) begin
            errors++; $display("FAIL clear_beats_lost: got %h score %0d expected %h score 1", obs, score, {3'd1, 2'd1, 4'b1100});
        end
        tick();
        checks++;
        if (obs !== {3'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clear_after: got %h expected %h", obs, {3'd1, 2'd1, 4'b1000});
        end
    endtask

    task automatic test_reset_mid();
        // Currently in SERVE: assert reset between clock edges.
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0} || score !== 16'd0) begin
            errors++; $display("FAIL reset_mid_serve: got %h score %0d expected %h score 0", obs, score, {3'd0, 2'd3, 4'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL post_reset_idle: got %0d expected 0", state_dbg);
        end
        press_start();
        for (int k = 0; k < 3; k++) begin
            wait_state(3'd2, "wait_play_f");
            lose_ball();
        end
        checks++;
        if (obs !== {3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL second_game_over: got %h expected %h", obs, {3'd4, 6'b000001});
        end
        tick();
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0} || score !== 16'd0) begin
            errors++; $display("FAIL reset_mid_game_over: got %h score %0d expected %h score 0", obs, score, {3'd0, 2'd3, 4'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        game_over_complete = 1'b1;
        tick();
        game_over_complete = 1'b0;
        tick();
        checks++;
        if (obs !== {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL idle_after_abort: got %h expected %h", obs, {3'd0, 2'd3, 4'b0});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_start_serve();
        test_scoring();
        test_lives();
        test_game_over_complete();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
